// File: rtl/cpu_sequencer.sv
// Multi-cycle sequencer for the single-cycle MIPS datapath sharing one memory bus.
// Walks FETCH -> EXEC -> (MEM -> WB) per instruction, with a bus-wait timeout into a sticky FAULT.
module cpu_sequencer #(
  parameter int Dbits   = 32,
  parameter int TIMEOUT = 15,
  parameter int CNTW    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [Dbits-1:0] pc,
  input  logic [Dbits-1:0] dp_mem_addr,
  input  logic [Dbits-1:0] dp_wdata,
  input  logic             dec_werf,
  input  logic             dec_memrd,
  input  logic             dec_memwr,
  output logic             bus_req,
  output logic             bus_we,
  output logic [Dbits-1:0] bus_addr,
  output logic [Dbits-1:0] bus_wdata,
  input  logic [Dbits-1:0] bus_rdata,
  input  logic             bus_ready,
  output logic [Dbits-1:0] instr,
  output logic [Dbits-1:0] mem_readdata,
  output logic             pc_enable,
  output logic             werf,
  output logic             busy,
  output logic             fault,
  output logic [CNTW-1:0]  instr_count
);

  localparam int WCW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    MEM   = 3'd3,
    WB    = 3'd4,
    FAULT = 3'd5
  } state_t;

  state_t         state_r;
  state_t         state_next_s;
  logic [WCW-1:0] wait_cnt_r;
  logic           timed_out_s;
  logic           mem_op_s;

  assign timed_out_s = (wait_cnt_r == WCW'(TIMEOUT));
  assign mem_op_s    = dec_memrd | dec_memwr;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; a ready on the cycle the counter hits TIMEOUT still completes the transfer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (run) state_next_s = FETCH;
        else     state_next_s = IDLE;
      end
      FETCH: begin
        if (bus_ready)        state_next_s = EXEC;
        else if (timed_out_s) state_next_s = FAULT;
        else                  state_next_s = FETCH;
      end
      EXEC: begin
        if (mem_op_s) state_next_s = MEM;
        else if (run) state_next_s = FETCH;
        else          state_next_s = IDLE;
      end
      MEM: begin
        if (bus_ready)        state_next_s = WB;
        else if (timed_out_s) state_next_s = FAULT;
        else                  state_next_s = MEM;
      end
      WB: begin
        if (run) state_next_s = FETCH;
        else     state_next_s = IDLE;
      end
      FAULT:   state_next_s = FAULT;
      default: state_next_s = IDLE;
    endcase
  end

  // Output decode from state; only the MEM bus fields follow the (held) datapath.
  always_comb begin
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = {Dbits{1'b0}};
    bus_wdata = {Dbits{1'b0}};
    pc_enable = 1'b0;
    werf      = 1'b0;
    busy      = 1'b1;
    fault     = 1'b0;
    case (state_r)
      IDLE: busy = 1'b0;
      FETCH: begin
        bus_req  = 1'b1;
        bus_addr = pc;
      end
      EXEC: begin
        if (mem_op_s) begin
          pc_enable = 1'b0;
          werf      = 1'b0;
        end else begin
          pc_enable = 1'b1;
          werf      = dec_werf;
        end
      end
      MEM: begin
        bus_req   = 1'b1;
        bus_we    = dec_memwr;
        bus_addr  = dp_mem_addr;
        bus_wdata = dp_wdata;
      end
      WB: begin
        pc_enable = 1'b1;
        werf      = dec_werf;
      end
      FAULT: begin
        busy  = 1'b0;
        fault = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  // Data latches, retire counter and bus wait counter (cleared whenever no request is waiting).
  always_ff @(posedge clk) begin
    if (reset) begin
      instr        <= {Dbits{1'b0}};
      mem_readdata <= {Dbits{1'b0}};
      instr_count  <= {CNTW{1'b0}};
      wait_cnt_r   <= {WCW{1'b0}};
    end else begin
      if (state_r == FETCH && bus_ready) instr <= bus_rdata;
      if (state_r == MEM && bus_ready) mem_readdata <= bus_rdata;
      if (pc_enable) instr_count <= instr_count + CNTW'(1);
      if (bus_req && !bus_ready) wait_cnt_r <= wait_cnt_r + WCW'(1);
      else                       wait_cnt_r <= {WCW{1'b0}};
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: a behavioural memory with programmable wait states and a
// small decoder model; expected retire records are queued at fetch completion and popped on pc_enable.
module tb_cpu_sequencer;

  localparam int DW  = 32;
  localparam int TMO = 15;
  localparam int CW  = 4;

  localparam logic [5:0] OP_RT  = 6'h00;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam logic [DW-1:0] W_ADD = 32'h0043_1020;
  localparam logic [DW-1:0] W_BEQ = 32'h1043_0003;
  localparam logic [DW-1:0] W_LW  = 32'h8C43_0010;
  localparam logic [DW-1:0] W_SW  = 32'hAC43_0020;

  typedef struct {
    logic          werf;
    logic          is_load;
    logic [DW-1:0] rdata;
    int            lat;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset, run;
  logic [DW-1:0] pc, dp_mem_addr, dp_wdata, bus_rdata;
  logic          bus_ready;
  logic          dec_werf, dec_memrd, dec_memwr;
  logic          bus_req, bus_we, pc_enable, werf, busy, fault;
  logic [DW-1:0] bus_addr, bus_wdata, instr, mem_readdata;
  logic [CW-1:0] instr_count;

  exp_t          exp_q[$];
  logic [CW-1:0] cnt_model;
  int            n_total = 0;
  int            n_bad   = 0;

  cpu_sequencer #(.Dbits(DW), .TIMEOUT(TMO), .CNTW(CW)) dut (
    .clk(clk), .reset(reset), .run(run), .pc(pc), .dp_mem_addr(dp_mem_addr),
    .dp_wdata(dp_wdata), .dec_werf(dec_werf), .dec_memrd(dec_memrd), .dec_memwr(dec_memwr),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ready(bus_ready), .instr(instr), .mem_readdata(mem_readdata),
    .pc_enable(pc_enable), .werf(werf), .busy(busy), .fault(fault), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Decoder model driven from the latched instruction.
  assign dec_memrd = (instr[31:26] == OP_LW);
  assign dec_memwr = (instr[31:26] == OP_SW);
  assign dec_werf  = (instr[31:26] == OP_RT) || (instr[31:26] == OP_LW);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction starting with the DUT in FETCH; acts as memory and checks the retire.
  task automatic do_instr(input logic [DW-1:0] word, input int fw, input int mw,
                          input logic [DW-1:0] addr, input logic [DW-1:0] wd,
                          input logic [DW-1:0] rd, input logic run_after);
    logic [5:0] op;
    bit         is_mem, is_st, fetched, done;
    int         waits;
    exp_t       e;
    op      = word[31:26];
    is_st   = (op == OP_SW);
    is_mem  = is_st || (op == OP_LW);
    dp_mem_addr = addr;
    dp_wdata    = wd;
    fetched = 1'b0;
    done    = 1'b0;
    waits   = 0;
    for (int c = 1; c <= 64 && !done; c++) begin
      check("werf_without_pc_enable", {63'd0, werf & ~pc_enable}, 64'd0);
      if (bus_req) begin
        if (!fetched) begin
          check("fetch_addr", bus_addr, pc);
          check("fetch_we", bus_we, 0);
          if (waits == fw) begin
            bus_ready = 1'b1;
            bus_rdata = word;
            fetched   = 1'b1;
            waits     = 0;
            e.werf    = (op == OP_RT) || (op == OP_LW);
            e.is_load = (op == OP_LW);
            e.rdata   = rd;
            e.lat     = 2 + fw + (is_mem ? 2 + mw : 0);
            exp_q.push_back(e);
            if (!is_mem) run = run_after;
          end else begin
            bus_ready = 1'b0;
            bus_rdata = 32'hBAD0_BAD0;
            waits++;
          end
        end else begin
          run = run_after;
          check("mem_addr", bus_addr, addr);
          check("mem_we", bus_we, is_st);
          if (is_st) check("mem_wdata", bus_wdata, wd);
          if (waits == mw) begin
            bus_ready = 1'b1;
            bus_rdata = rd;
            waits     = 0;
          end else begin
            bus_ready = 1'b0;
            bus_rdata = 32'hBAD0_BAD0;
            waits++;
          end
        end
      end else begin
        bus_ready = 1'b0;
      end
      if (pc_enable) begin
        check("retire_pending", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("retire_werf", werf, e.werf);
          check("retire_latency", c, e.lat);
          if (e.is_load) check("load_data", mem_readdata, e.rdata);
        end
        cnt_model = cnt_model + 4'd1;
        pc        = pc + 32'd4;
        done      = 1'b1;
      end
      step();
      if (done) begin
        bus_ready = 1'b0;
        check("instr_count", instr_count, cnt_model);
        check("busy_after_retire", busy, run_after);
        check("req_after_retire", bus_req, run_after);
        check("no_double_retire", pc_enable, 0);
        check("no_fault", fault, 0);
      end
    end
    check("retire_seen", done, 1);
  endtask

  initial begin
    logic [DW-1:0] w;
    reset = 1'b1;
    run = 1'b0;
    pc = 32'h0040_0000;
    dp_mem_addr = 32'd0;
    dp_wdata = 32'd0;
    bus_rdata = 32'd0;
    bus_ready = 1'b0;
    cnt_model = 4'd0;
    step();
    step();
    check("rst_bus_req", bus_req, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_pc_enable", pc_enable, 0);
    check("rst_werf", werf, 0);
    check("rst_busy", busy, 0);
    check("rst_fault", fault, 0);
    check("rst_instr", instr, 0);
    check("rst_mem_readdata", mem_readdata, 0);
    check("rst_instr_count", instr_count, 0);
    reset = 1'b0;
    step();
    check("idle_busy", busy, 0);
    check("idle_req", bus_req, 0);
    run = 1'b1;
    step();

    do_instr(W_ADD, 0, 0, 32'h0, 32'h0, 32'h0, 1'b1);
    do_instr(W_LW, 0, 3, 32'h0000_0200, 32'h0, 32'hDEAD_BEEF, 1'b1);
    do_instr(W_SW, 0, 0, 32'h0000_0100, 32'h0000_0055, 32'h1234_5678, 1'b1);
    do_instr(W_BEQ, 2, 0, 32'h0, 32'h0, 32'h0, 1'b1);
    do_instr(W_LW, 1, 2, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, 1'b0);
    step();
    check("stopped_busy", busy, 0);
    check("stopped_req", bus_req, 0);
    run = 1'b1;
    step();
    do_instr(W_ADD, TMO, 0, 32'h0, 32'h0, 32'h0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(0, 3))
        0:       w = W_ADD;
        1:       w = W_BEQ;
        2:       w = W_LW;
        default: w = W_SW;
      endcase
      do_instr(w, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               $urandom, $urandom, $urandom, 1'b1);
    end

    bus_ready = 1'b0;
    for (int c = 1; c <= TMO + 1; c++) begin
      check("timeout_req", bus_req, 1);
      check("timeout_no_early_fault", fault, 0);
      step();
    end
    check("fault_set", fault, 1);
    check("fault_req", bus_req, 0);
    check("fault_busy", busy, 0);
    check("fault_pc_enable", pc_enable, 0);
    check("fault_addr", bus_addr, 0);
    repeat (3) step();
    check("fault_sticky", fault, 1);
    check("fault_sticky_req", bus_req, 0);

    reset = 1'b1;
    step();
    reset = 1'b0;
    cnt_model = 4'd0;
    check("recover_fault", fault, 0);
    check("recover_count", instr_count, cnt_model);
    step();
    check("refetch_req", bus_req, 1);
    step();
    reset = 1'b1;
    step();
    check("midfetch_reset_req", bus_req, 0);
    check("midfetch_reset_busy", busy, 0);
    reset = 1'b0;
    run = 1'b0;
    step();
    check("post_reset_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
